mem_byte_port: RTL and testbench

Bridges the control unit's memory handshake (MFA, READ_WRITE, WORD_BYTE, MFC) and the MAR/MBR registers to the 8-bit external memory bus. It sits directly downstream of the control unit and the MAR/MBR. A word access becomes four sequential byte transfers, assembled or split big-endian. A byte access becomes one transfer. MFC is raised only when the whole access is complete.

---
 rtl/mem_byte_port.sv | 172 +++++++++++++++++
 tb/tb_mem_byte_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_port.sv
// Byte-serial memory bridge: turns a control-unit word/byte request into one or
// four big-endian 8-bit bus transfers and raises MFC once the access is complete.
module mem_byte_port #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MFA,
  input  logic                  READ_WRITE,
  input  logic                  WORD_BYTE,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemWrData,
  input  logic [7:0]            MemRdData,
  output logic                  MemEn,
  output logic                  MemWe,
  input  logic                  MemReady
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic                  wb_q, wb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           dout_q, dout_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wr_data_q, mem_wr_data_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mfc_q, mfc_d;
  logic                  last_byte;
  logic [31:0]           merged;

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] k,
                                          input logic word);
    logic [7:0] b;
    b = d[7:0];
    if (word) begin
      case (k)
        2'd0:    b = d[31:24];
        2'd1:    b = d[23:16];
        2'd2:    b = d[15:8];
        default: b = d[7:0];
      endcase
    end
    return b;
  endfunction

  // Word accesses walk the aligned 4-byte block; only the low two bits change.
  function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] k, input logic word);
    return word ? {a[ADDR_WIDTH-1:2], k} : a;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] acc, input logic [7:0] rd,
                                             input logic [1:0] k);
    logic [31:0] r;
    r = acc;
    case (k)
      2'd0:    r[31:24] = rd;
      2'd1:    r[23:16] = rd;
      2'd2:    r[15:8]  = rd;
      default: r[7:0]   = rd;
    endcase
    return r;
  endfunction

  assign last_byte = wb_q ? (cnt_q == 2'd3) : 1'b1;
  assign merged    = byte_merge(asm_q, MemRdData, cnt_q);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (MFA) state_d = XFER;
      XFER:    if (MemReady && last_byte) state_d = MFA ? DONE : IDLE;
      DONE:    if (!MFA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    rw_d          = rw_q;
    wb_d          = wb_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    asm_d         = asm_q;
    dout_d        = dout_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    case (state_q)
      IDLE: begin
        if (MFA) begin
          rw_d          = READ_WRITE;
          wb_d          = WORD_BYTE;
          addr_d        = Address;
          wdata_d       = DataIn;
          cnt_d         = 2'd0;
          mem_addr_d    = byte_addr(Address, 2'd0, WORD_BYTE);
          mem_wr_data_d = byte_sel(DataIn, 2'd0, WORD_BYTE);
        end
      end
      XFER: begin
        if (MemReady) begin
          if (rw_q) asm_d = merged;
          if (last_byte) begin
            if (rw_q) dout_d = wb_q ? merged : {24'd0, MemRdData};
          end else begin
            cnt_d         = cnt_q + 2'd1;
            mem_addr_d    = byte_addr(addr_q, cnt_q + 2'd1, wb_q);
            mem_wr_data_d = byte_sel(wdata_q, cnt_q + 2'd1, wb_q);
          end
        end
      end
      default: ;
    endcase
    mem_en_d = (state_d == XFER);
    mem_we_d = (state_d == XFER) && !rw_d;
    // MFC follows DONE by one registered cycle and drops on the first edge that sees MFA low.
    mfc_d    = (state_q == DONE) && MFA;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q         <= 2'd0;
      rw_q          <= 1'b0;
      wb_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      asm_q         <= 32'd0;
      dout_q        <= 32'd0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= 8'd0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mfc_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rw_q          <= rw_d;
      wb_q          <= wb_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      asm_q         <= asm_d;
      dout_q        <= dout_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mfc_q         <= mfc_d;
    end
  end

  assign DataOut   = dout_q;
  assign MFC       = mfc_q;
  assign MemAddr   = mem_addr_q;
  assign MemWrData = mem_wr_data_q;
  assign MemEn     = mem_en_q;
  assign MemWe     = mem_we_q;

endmodule

// File: tb/tb_mem_byte_port.sv
// Scoreboard bench for mem_byte_port: directed accesses queue their expected bus
// transfers and completions; a responder/monitor pair checks them as they occur.
module tb_mem_byte_port;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MFA = 1'b0;
  logic        READ_WRITE = 1'b0;
  logic        WORD_BYTE = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] DataIn = 32'd0;
  logic [31:0] DataOut;
  logic        MFC;
  logic [31:0] MemAddr;
  logic [7:0]  MemWrData;
  logic [7:0]  MemRdData = 8'd0;
  logic        MemEn;
  logic        MemWe;
  logic        MemReady = 1'b0;

  mem_byte_port #(.ADDR_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .MFA(MFA), .READ_WRITE(READ_WRITE), .WORD_BYTE(WORD_BYTE),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRdData(MemRdData),
    .MemEn(MemEn), .MemWe(MemWe), .MemReady(MemReady)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] addr; logic we; logic [7:0] wd; } xfer_t;
  typedef struct { logic [31:0] dout; int lat; } res_t;

  xfer_t      xq[$];
  res_t       rq[$];
  logic [7:0] mem [logic [31:0]];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         accept_cyc = 0;
  int         stall_n = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic push_x(input logic [31:0] a, input logic we, input logic [7:0] wd);
    xfer_t e;
    e.addr = a; e.we = we; e.wd = wd;
    xq.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] d, input int lat);
    res_t r;
    r.dout = d; r.lat = lat;
    rq.push_back(r);
  endtask

  // Called just after a falling edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic rw, input logic wb, input logic [31:0] a, input logic [31:0] d);
    READ_WRITE = rw; WORD_BYTE = wb; Address = a; DataIn = d; MFA = 1'b1;
    @(posedge Clk);
    #1 accept_cyc = cyc;
    check1("mem_en_after_accept", MemEn, 1'b1);
  endtask

  task automatic wait_mfc(input string name);
    int t;
    t = 0;
    while (!MFC && t < 100) begin
      @(negedge Clk);
      t++;
    end
    check1(name, MFC, 1'b1);
  endtask

  task automatic release_mfa(input string name);
    MFA = 1'b0;
    @(negedge Clk);
    check1(name, MFC, 1'b0);
  endtask

  // Memory responder: inserts stall_n wait cycles before each byte, then acknowledges.
  initial begin
    int wait_cnt;
    xfer_t e;
    wait_cnt = 0;
    forever begin
      @(negedge Clk);
      if (Reset && MemEn) begin
        if (wait_cnt < stall_n) begin
          MemReady = 1'b0;
          wait_cnt++;
        end else begin
          MemReady = 1'b1;
          wait_cnt = 0;
          MemRdData = mem.exists(MemAddr) ? mem[MemAddr] : 8'h00;
          if (xq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_xfer: got transfer at 0x%08h, expected none", MemAddr);
          end else begin
            e = xq.pop_front();
            check("xfer_addr", MemAddr, e.addr);
            check1("xfer_we", MemWe, e.we);
            if (e.we) check("xfer_wdata", {24'd0, MemWrData}, {24'd0, e.wd});
          end
        end
      end else begin
        MemReady = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor: every rising MFC must match a queued result.
  initial begin
    logic mfc_prev;
    res_t r;
    mfc_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (MFC && !mfc_prev) begin
        if (rq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_mfc: got MFC=1 at cycle %0d, expected none", cyc);
        end else begin
          r = rq.pop_front();
          check("dataout", DataOut, r.dout);
          check("latency", 32'(cyc - accept_cyc), 32'(r.lat));
        end
      end
      mfc_prev = MFC;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h100] = 8'h12; mem[32'h101] = 8'h34; mem[32'h102] = 8'h56; mem[32'h103] = 8'h78;
    mem[32'h203] = 8'hA5; mem[32'h000] = 8'h3C;

    Reset = 1'b1;
    #1 Reset = 1'b0;
    #1;
    check("rst_dataout", DataOut, 32'd0);
    check1("rst_mfc", MFC, 1'b0);
    check1("rst_memen", MemEn, 1'b0);
    check1("rst_memwe", MemWe, 1'b0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_memwrdata", {24'd0, MemWrData}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Word read at unaligned 0x102 reads the aligned block 0x100..0x103.
    push_x(32'h100, 1'b0, 8'h00); push_x(32'h101, 1'b0, 8'h00);
    push_x(32'h102, 1'b0, 8'h00); push_x(32'h103, 1'b0, 8'h00);
    push_r(32'h12345678, 5);
    issue(1'b1, 1'b1, 32'h102, 32'h0);
    wait_mfc("word_read_mfc");
    repeat (3) begin
      @(negedge Clk);
      check1("mfc_hold", MFC, 1'b1);
    end
    release_mfa("mfc_release");
    check1("idle_memen", MemEn, 1'b0);

    // Byte read one cycle after release.
    push_x(32'h203, 1'b0, 8'h00);
    push_r(32'h000000A5, 2);
    issue(1'b1, 1'b0, 32'h203, 32'h0);
    wait_mfc("byte_read_mfc");
    release_mfa("byte_read_release");

    // Word write, two wait cycles before each byte.
    stall_n = 2;
    push_x(32'h200, 1'b1, 8'hDE); push_x(32'h201, 1'b1, 8'hAD);
    push_x(32'h202, 1'b1, 8'hBE); push_x(32'h203, 1'b1, 8'hEF);
    push_r(32'h000000A5, 13);
    issue(1'b0, 1'b1, 32'h200, 32'hDEADBEEF);
    wait_mfc("word_write_mfc");
    release_mfa("word_write_release");
    stall_n = 0;
    @(negedge Clk);

    // MFA dropped after the second byte: all bytes still go out, no MFC.
    push_x(32'h300, 1'b1, 8'h11); push_x(32'h301, 1'b1, 8'h22);
    push_x(32'h302, 1'b1, 8'h33); push_x(32'h303, 1'b1, 8'h44);
    issue(1'b0, 1'b1, 32'h300, 32'h11223344);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    MFA = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      check1("abort_no_mfc", MFC, 1'b0);
    end
    check1("abort_idle_memen", MemEn, 1'b0);
    check("abort_all_bytes", 32'(xq.size()), 32'd0);
    check("abort_dataout", DataOut, 32'h000000A5);

    // Reset while the third byte of a word read is on the bus.
    push_x(32'h100, 1'b0, 8'h00); push_x(32'h101, 1'b0, 8'h00);
    push_x(32'h102, 1'b0, 8'h00); push_x(32'h103, 1'b0, 8'h00);
    issue(1'b1, 1'b1, 32'h100, 32'h0);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    #2 Reset = 1'b0;
    MFA = 1'b0;
    #1;
    check1("midrst_memen", MemEn, 1'b0);
    check1("midrst_mfc", MFC, 1'b0);
    check("midrst_dataout", DataOut, 32'd0);
    check("midrst_memaddr", MemAddr, 32'd0);
    check("midrst_pending", 32'(xq.size()), 32'd1);
    xq.delete();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    push_x(32'h000, 1'b0, 8'h00);
    push_r(32'h0000003C, 2);
    issue(1'b1, 1'b0, 32'h0, 32'h0);
    wait_mfc("post_reset_mfc");
    release_mfa("post_reset_release");
    repeat (2) @(negedge Clk);

    check("xfer_queue_drained", 32'(xq.size()), 32'd0);
    check("result_queue_drained", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
